// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt + rvalid and
// buffers returned words with their PC in an in-order queue presented to decode.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CAP = (CW+1)'(QDEPTH);

    logic [29:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          pop;
    logic          grant;
    logic          resp;
    logic          push;
    logic [CW:0]   credit_sum;
    logic [CW-1:0] live;
    logic [31:0]   pc_tag;
    logic [CW-1:0] count_after_pop;
    logic [PW-1:0] rd_next;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign pop        = id_valid & id_ready;
    assign credit_sum = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign imem_req   = (credit_sum < CAP) & ~redirect_valid & ~rst;
    assign imem_addr  = {pc, 2'b00};
    assign grant      = imem_req & imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp = imem_rvalid & (outstanding != '0);
    assign push = resp & (drop == '0) & ~redirect_valid;

    // Live fetches occupy the PCs just below the current pc, oldest first.
    assign live   = outstanding - drop;
    assign pc_tag = {pc, 2'b00} - {{(30-CW){1'b0}}, live, 2'b00};

    assign count_after_pop = count - {{(CW-1){1'b0}}, pop};
    assign rd_next         = rd_ptr + {{(PW-1){1'b0}}, pop};
    assign id_valid        = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC[31:2];
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc[31:2];
            end else if (grant) begin
                pc <= pc + 30'd1;
            end
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            // On redirect every fetch still in flight is stale, whether or not it already was.
            if (redirect_valid) begin
                drop <= outstanding - CW'(resp);
            end else if (resp && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            count  <= count_after_pop + CW'(push);
            rd_ptr <= rd_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Output registers track the next head; they hold their value when the queue drains.
            if (count_after_pop != '0) begin
                id_pc    <= q_pc[rd_next];
                id_instr <= q_instr[rd_next];
            end else if (push) begin
                id_pc    <= pc_tag;
                id_instr <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc_tag;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with a fixed-latency instruction memory model
// returning mem[a] = a ^ 32'hA5A5_0000.
module tb_inst_fetch_stage;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt       = 1'b1;
    logic        imem_rvalid    = 1'b0;
    logic [31:0] imem_rdata     = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_valid;
    logic        id_ready       = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int compared   = 0;
    int mismatched = 0;
    int mem_lat    = 1;
    int cyc        = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    inst_fetch_stage #(.RESET_PC(32'h0000_3000), .QDEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    // Memory: a grant at edge e returns its word in the cycle sampled at edge e+mem_lat.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            if (imem_req && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + mem_lat);
            end
            #1;
            if (pend_due.size() != 0 && pend_due[0] <= cyc + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr[0] ^ 32'hA5A5_0000;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Returns at the falling edge that starts the first cycle out of reset.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = ready;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [31:0] exp_pc);
        compared++;
        if (id_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_valid: got %0b expected 1", name, id_valid);
        end
        compared++;
        if (id_pc !== exp_pc) begin
            mismatched++;
            $display("[TB] FAIL %s_pc: got %h expected %h", name, id_pc, exp_pc);
        end
        compared++;
        if (id_instr !== (exp_pc ^ 32'hA5A5_0000)) begin
            mismatched++;
            $display("[TB] FAIL %s_instr: got %h expected %h", name, id_instr, exp_pc ^ 32'hA5A5_0000);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_bit("reset_req", imem_req, 1'b0);
            check_word("reset_addr", imem_addr, 32'h0000_3000);
            check_bit("reset_id_valid", id_valid, 1'b0);
            check_word("reset_id_pc", id_pc, 32'h0);
            check_word("reset_id_instr", id_instr, 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_bit("first_req", imem_req, 1'b1);
        check_word("first_addr", imem_addr, 32'h0000_3000);
        check_bit("first_id_valid", id_valid, 1'b0);
        @(negedge clk);
        #1;
        check_bit("second_id_valid", id_valid, 1'b0);
        check_word("second_addr", imem_addr, 32'h0000_3004);
        @(negedge clk);
        #1;
        check_head("first_delivery", 32'h0000_3000);
    endtask

    task automatic test_straight;
        mem_lat = 1;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            check_head("straight", 32'h0000_3000 + 32'(4 * k));
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int grants = 0;
        mem_lat = 1;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req && imem_gnt) grants++;
            if (i == 9) begin
                check_bit("bp_req_stalled", imem_req, 1'b0);
                check_head("bp_held", 32'h0000_3000);
            end
            @(negedge clk);
        end
        compared++;
        if (grants != 4) begin
            mismatched++;
            $display("[TB] FAIL bp_grants: got %0d expected 4", grants);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_head("bp_drain", 32'h0000_3000 + 32'(4 * k));
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        mem_lat = 3;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4002;
        #1;
        check_bit("redir_req_blocked", imem_req, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check_bit("redir_target_req", imem_req, 1'b1);
        check_word("redir_target_addr", imem_addr, 32'h0000_4000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            check_bit("redir_stale_dropped", id_valid, 1'b0);
            @(negedge clk);
        end
        #1;
        check_head("redir_first", 32'h0000_4000);
        @(negedge clk);
        #1;
        check_head("redir_second", 32'h0000_4004);
        @(negedge clk);
    endtask

    task automatic test_redirect_pop;
        mem_lat = 1;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5003;
        #1;
        check_head("rp_popped", 32'h0000_3008);
        check_bit("rp_req_blocked", imem_req, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check_bit("rp_no_stale_valid", id_valid, 1'b0);
        check_bit("rp_target_req", imem_req, 1'b1);
        check_word("rp_target_addr", imem_addr, 32'h0000_5000);
        @(negedge clk);
        #1;
        check_bit("rp_gap_valid", id_valid, 1'b0);
        @(negedge clk);
        #1;
        check_head("rp_first", 32'h0000_5000);
        @(negedge clk);
        #1;
        check_head("rp_second", 32'h0000_5004);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        mem_lat = 3;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        #1;
        check_head("mid_before", 32'h0000_3000);
        rst = 1'b1;
        #1;
        check_bit("mid_req", imem_req, 1'b0);
        check_word("mid_addr", imem_addr, 32'h0000_3000);
        check_bit("mid_id_valid", id_valid, 1'b0);
        check_word("mid_id_pc", id_pc, 32'h0);
        check_word("mid_id_instr", id_instr, 32'h0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        id_ready = 1'b1;
        #1;
        check_bit("mid_restart_req", imem_req, 1'b1);
        check_word("mid_restart_addr", imem_addr, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_bit("mid_no_late_rvalid", id_valid, 1'b0);
        end
        @(negedge clk);
        #1;
        check_head("mid_restart_first", 32'h0000_3000);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_straight;
        test_backpressure;
        test_redirect;
        test_redirect_pop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
